// File: rtl/lcfg_pkg.sv
// Shared definitions for the local-config target: one-hot state layout,
// the out-of-range read pattern and the register index width helper.
package lcfg_pkg;

    localparam int unsigned S_IDLE  = 0;
    localparam int unsigned S_WAIT  = 1;
    localparam int unsigned S_RESP  = 2;
    localparam int unsigned S_RECOV = 3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'(1 << S_IDLE),
        ST_WAIT  = 4'(1 << S_WAIT),
        ST_RESP  = 4'(1 << S_RESP),
        ST_RECOV = 4'(1 << S_RECOV)
    } state_t;

    localparam logic [31:0] ERR_RD_PATTERN = 32'hBAD0_0000;

    // Index width: enough bits to address n registers, never less than one.
    function automatic int unsigned calc_iw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcfg_cfgi_regbank.sv
// Register bank for the config target: NUM_REGS x 32-bit registers with one
// write port, a combinational read mux (out-of-range index reads 0) and a
// per-register write strobe that pulses the cycle after a write.
module lcfg_cfgi_regbank
    import lcfg_pkg::*;
#(
    parameter int unsigned            NUM_REGS  = 8,
    parameter int unsigned            IW        = calc_iw(NUM_REGS),
    parameter logic [NUM_REGS*32-1:0] REG_RESET = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [IW-1:0]            rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_stb
);

    logic [NUM_REGS*32-1:0] regs;

    // Register storage and write strobe generation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs       <= REG_RESET;
            reg_wr_stb <= '0;
        end else begin
            reg_wr_stb <= '0;
            if (wr_en) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx == IW'(i)) begin
                        regs[32*i +: 32] <= wr_data;
                        reg_wr_stb[i]    <= 1'b1;
                    end
                end
            end
        end
    end

    // Read mux; indices past the last register fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IW'(i)) rd_data = regs[32*i +: 32];
        end
    end

    assign reg_out = regs;

endmodule

// File: rtl/lcfg_cfgi_target.sv
// Config-bus target: decodes an address window on the irdy/trdy bus, inserts
// WAIT_CYCLES wait states and answers with a single-cycle trdy.
// Optional feature macro: LCFG_CFGI_ERR_EN (sticky cfgi_err, error read pattern,
// error clear via bit31 written to the last register).
module lcfg_cfgi_target
    import lcfg_pkg::*;
#(
    parameter logic [15:0]            BASE_ADDR   = 16'h0040,
    parameter logic [15:0]            ADDR_MASK   = 16'hFFF0,
    parameter int unsigned            NUM_REGS    = 8,
    parameter int unsigned            WAIT_CYCLES = 0,
    parameter logic [NUM_REGS*32-1:0] REG_RESET   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfgi_irdy,
    input  logic [15:0]              cfgi_addr,
    input  logic                     cfgi_write,
    input  logic [31:0]              cfgi_wr_data,
    output logic                     cfgi_trdy,
    output logic [31:0]              cfgi_rd_data,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_stb,
    output logic                     cfgi_err
);

    localparam int unsigned IW        = calc_iw(NUM_REGS);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t      state;
    logic [15:0] cap_addr;
    logic        cap_write;
    logic [31:0] cap_data;
    logic [3:0]  wait_cnt;

    logic          hit, start, enter_resp, abort;
    logic [15:0]   req_addr;
    logic          req_write;
    logic [IW-1:0] req_idx, cap_idx;
    logic          req_in_range, cap_in_range;
    logic [31:0]   bank_rd_data, resp_rd_data, bank_wr_data;
    logic          bank_wr_en;

    assign hit        = (cfgi_addr & ADDR_MASK) == BASE_ADDR;
    assign start      = (state == ST_IDLE) && cfgi_irdy && hit;
    assign enter_resp = (start && (WAIT_CYCLES == 0)) ||
                        ((state == ST_WAIT) && cfgi_irdy && (wait_cnt == '0));
    assign abort      = (state == ST_WAIT) && !cfgi_irdy;

    // With no wait states the response is formed from the live bus in IDLE;
    // once captured, only the captured copy is used.
    assign req_addr     = (state == ST_IDLE) ? cfgi_addr  : cap_addr;
    assign req_write    = (state == ST_IDLE) ? cfgi_write : cap_write;
    assign req_idx      = req_addr[IW-1:0];
    assign cap_idx      = cap_addr[IW-1:0];
    assign req_in_range = 32'(req_idx) < NUM_REGS;
    assign cap_in_range = 32'(cap_idx) < NUM_REGS;
    assign bank_wr_en   = (state == ST_RESP) && cap_write && cap_in_range;

    lcfg_cfgi_regbank #(
        .NUM_REGS  (NUM_REGS),
        .IW        (IW),
        .REG_RESET (REG_RESET)
    ) u_regbank (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (bank_wr_en),
        .wr_idx     (cap_idx),
        .wr_data    (bank_wr_data),
        .rd_idx     (req_idx),
        .rd_data    (bank_rd_data),
        .reg_out    (reg_out),
        .reg_wr_stb (reg_wr_stb)
    );

    // Read response value for the request entering RESP; writes return zero.
    always_comb begin
        resp_rd_data = '0;
        if (!req_write) begin
            if (req_in_range) begin
                resp_rd_data = bank_rd_data;
            end
`ifdef LCFG_CFGI_ERR_EN
            else begin
                resp_rd_data = ERR_RD_PATTERN | {16'h0000, req_addr};
            end
`endif
        end
    end

    // Data presented to the bank; bit31 of the last register is the error-clear control.
    always_comb begin
        bank_wr_data = cap_data;
`ifdef LCFG_CFGI_ERR_EN
        if (32'(cap_idx) == NUM_REGS - 1) bank_wr_data[31] = 1'b0;
`endif
    end

    // Request FSM with wait counter, capture registers and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cap_addr     <= '0;
            cap_write    <= 1'b0;
            cap_data     <= '0;
            wait_cnt     <= '0;
            cfgi_trdy    <= 1'b0;
            cfgi_rd_data <= '0;
        end else begin
            cfgi_trdy    <= 1'b0;
            cfgi_rd_data <= '0;
            if (enter_resp) begin
                cfgi_trdy    <= 1'b1;
                cfgi_rd_data <= resp_rd_data;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        cap_addr  <= cfgi_addr;
                        cap_write <= cfgi_write;
                        cap_data  <= cfgi_wr_data;
                        if (WAIT_CYCLES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (abort)           state <= ST_IDLE;
                    else if (enter_resp) state <= ST_RESP;
                    else                 wait_cnt <= wait_cnt - 4'd1;
                end
                ST_RESP: state <= ST_RECOV;
                ST_RECOV: begin
                    if (!cfgi_irdy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LCFG_CFGI_ERR_EN
    logic err_q;

    // Sticky error: set by out-of-range access or wait abort, cleared by bit31 to the last register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (abort || (enter_resp && !req_in_range)) begin
            err_q <= 1'b1;
        end else if (bank_wr_en && (32'(cap_idx) == NUM_REGS - 1) && cap_data[31]) begin
            err_q <= 1'b0;
        end
    end

    assign cfgi_err = err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[15:IW];
    assign cfgi_err         = 1'b0;
`endif

endmodule
